// File: rtl/udp_arp_echo_engine.sv
// UDP echo / ARP responder with ping-pong payload banks between the RX parser and TX framer.
// Headers and checksums are frozen in REQ; the framer pulls bytes through a registered read port.
module udp_arp_echo_engine #(
  parameter logic [47:0] LOCAL_MAC   = 48'h02123456789A,
  parameter logic [31:0] LOCAL_IP    = 32'h0A0A0A64,
  parameter logic [15:0] LOCAL_PORT  = 16'd5005,
  parameter int unsigned ADDR_W      = 9,
  parameter bit          FILTER_PORT = 1'b1,
  parameter bit          UDP_CSUM    = 1'b1,
  parameter bit          PAD_MIN     = 1'b1,
  parameter logic [15:0] IP_ID_INIT  = 16'h1234,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_req,
  input  logic [47:0] arp_src_mac,
  input  logic [31:0] arp_src_ip,
  input  logic        pay_vld,
  input  logic [7:0]  pay_byte,
  input  logic [15:0] pay_idx,
  input  logic        pay_last,
  input  logic        udp_done,
  input  logic [47:0] udp_src_mac,
  input  logic [31:0] udp_src_ip,
  input  logic [15:0] udp_src_port,
  input  logic [15:0] udp_dst_port,
  output logic        tx_req,
  output logic [15:0] tx_len,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic [15:0] tx_rd_idx,
  output logic [7:0]  tx_rd_byte,
  output logic [15:0] rx_drop_cnt,
  output logic [15:0] tx_frame_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  state_e state_q, state_d;
  logic   sel_load, send_done, in_range, accept;

  logic [7:0]  mem [0:2*DEPTH-1];
  logic [47:0] meta_mac_q  [2];
  logic [31:0] meta_ip_q   [2];
  logic [15:0] meta_port_q [2];
  logic [15:0] meta_len_q  [2];
  logic [31:0] meta_acc_q  [2];
  logic [1:0]  bank_full_q;
  logic        wr_bank_q, rd_bank_q;
  logic        oversize_q, last_seen_q;
  logic [15:0] rx_len_q, rx_drop_cnt_q, tx_frame_cnt_q, ident_q;
  logic [31:0] acc_q, acc_term;

  logic        arp_pend_q;
  logic [47:0] arp_mac_q;
  logic [31:0] arp_ip_q;

  logic        src_arp_q;
  logic [47:0] peer_mac_q;
  logic [31:0] peer_ip_q, peer_acc_q;
  logic [15:0] peer_port_q, len_q;
  logic [335:0] hdr_q, hdr_d, hdr_sh;
  logic [15:0] tot_len, udp_len, ip_csum, udp_csum, udp_ones, frame_len, raw_len, pay_off;
  logic [31:0] ip_sum, udp_sum;
  logic [7:0]  rd_byte_d, tx_rd_byte_q;

  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [31:0] t;
    t = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
    return t[15:0];
  endfunction

  assign in_range  = (pay_idx >> ADDR_W) == 16'd0;
  assign accept    = !oversize_q && (!FILTER_PORT || udp_dst_port == LOCAL_PORT) &&
                     !bank_full_q[wr_bank_q];
  assign send_done = (state_q == StSend) && tx_done;
  assign acc_term  = pay_idx[0] ? {24'd0, pay_byte} : {16'd0, pay_byte, 8'd0};

  // A full write bank is still owed to the transmitter, so its payload must not be overwritten.
  always_ff @(posedge clk) begin
    if (pay_vld && in_range && !bank_full_q[wr_bank_q]) begin
      mem[{wr_bank_q, pay_idx[ADDR_W-1:0]}] <= pay_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oversize_q    <= 1'b0;
      last_seen_q   <= 1'b0;
      rx_len_q      <= 16'd0;
      acc_q         <= 32'd0;
      wr_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      rx_drop_cnt_q <= 16'd0;
    end else begin
      if (pay_vld) begin
        if (!in_range) oversize_q <= 1'b1;
        if (pay_last) begin
          last_seen_q <= 1'b1;
          rx_len_q    <= pay_idx + 16'd1;
        end
        acc_q <= ((pay_idx == 16'd0) ? 32'd0 : acc_q) + acc_term;
      end
      if (send_done && !src_arp_q) bank_full_q[rd_bank_q] <= 1'b0;
      if (udp_done) begin
        oversize_q  <= 1'b0;
        last_seen_q <= 1'b0;
        acc_q       <= 32'd0;
        if (accept) begin
          meta_mac_q[wr_bank_q]  <= udp_src_mac;
          meta_ip_q[wr_bank_q]   <= udp_src_ip;
          meta_port_q[wr_bank_q] <= udp_src_port;
          meta_len_q[wr_bank_q]  <= last_seen_q ? rx_len_q : 16'd0;
          meta_acc_q[wr_bank_q]  <= acc_q;
          bank_full_q[wr_bank_q] <= 1'b1;
          wr_bank_q              <= ~wr_bank_q;
        end else if (rx_drop_cnt_q != 16'hFFFF) begin
          rx_drop_cnt_q <= rx_drop_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_busy && (arp_pend_q || bank_full_q[rd_bank_q])) begin
          state_d  = StReq;
          sel_load = 1'b1;
        end
      end
      StReq:   state_d = StSend;
      StSend:  if (tx_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tot_len  = 16'd28 + len_q;
    udp_len  = 16'd8 + len_q;
    ip_sum   = 32'h4500 + {16'd0, tot_len} + {16'd0, ident_q} + 32'h4000 + {16'd0, TTL, 8'h11} +
               {16'd0, LOCAL_IP[31:16]} + {16'd0, LOCAL_IP[15:0]} +
               {16'd0, peer_ip_q[31:16]} + {16'd0, peer_ip_q[15:0]};
    ip_csum  = ~fold16(ip_sum);
    udp_sum  = peer_acc_q + {16'd0, LOCAL_IP[31:16]} + {16'd0, LOCAL_IP[15:0]} +
               {16'd0, peer_ip_q[31:16]} + {16'd0, peer_ip_q[15:0]} + 32'h11 +
               {16'd0, udp_len} + {16'd0, udp_len} + {16'd0, LOCAL_PORT} + {16'd0, peer_port_q};
    udp_ones = ~fold16(udp_sum);
    udp_csum = !UDP_CSUM ? 16'h0000 : ((udp_ones == 16'h0000) ? 16'hFFFF : udp_ones);
    if (src_arp_q) begin
      hdr_d = {peer_mac_q, LOCAL_MAC, 16'h0806, 64'h0001_0800_0604_0002,
               LOCAL_MAC, LOCAL_IP, peer_mac_q, peer_ip_q};
    end else begin
      hdr_d = {peer_mac_q, LOCAL_MAC, 16'h0800, 16'h4500, tot_len, ident_q, 16'h4000, TTL, 8'h11,
               ip_csum, LOCAL_IP, peer_ip_q, LOCAL_PORT, peer_port_q, udp_len, udp_csum};
    end
    raw_len   = src_arp_q ? 16'd42 : 16'd42 + len_q;
    frame_len = (PAD_MIN && raw_len < 16'd60) ? 16'd60 : raw_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      arp_pend_q     <= 1'b0;
      arp_mac_q      <= 48'd0;
      arp_ip_q       <= 32'd0;
      rd_bank_q      <= 1'b0;
      ident_q        <= IP_ID_INIT;
      tx_frame_cnt_q <= 16'd0;
      src_arp_q      <= 1'b0;
      peer_mac_q     <= 48'd0;
      peer_ip_q      <= 32'd0;
      peer_port_q    <= 16'd0;
      peer_acc_q     <= 32'd0;
      len_q          <= 16'd0;
      hdr_q          <= '0;
      tx_rd_byte_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      // A fresh request wins over the clear from a completing ARP reply.
      if (arp_req) begin
        arp_pend_q <= 1'b1;
        arp_mac_q  <= arp_src_mac;
        arp_ip_q   <= arp_src_ip;
      end else if (send_done && src_arp_q) begin
        arp_pend_q <= 1'b0;
      end
      if (sel_load) begin
        src_arp_q   <= arp_pend_q;
        peer_mac_q  <= arp_pend_q ? arp_mac_q : meta_mac_q[rd_bank_q];
        peer_ip_q   <= arp_pend_q ? arp_ip_q : meta_ip_q[rd_bank_q];
        peer_port_q <= meta_port_q[rd_bank_q];
        peer_acc_q  <= meta_acc_q[rd_bank_q];
        len_q       <= arp_pend_q ? 16'd0 : meta_len_q[rd_bank_q];
      end
      if (state_q == StReq) hdr_q <= hdr_d;
      if (send_done) begin
        tx_frame_cnt_q <= tx_frame_cnt_q + 16'd1;
        if (!src_arp_q) begin
          rd_bank_q <= ~rd_bank_q;
          ident_q   <= ident_q + 16'd1;
        end
      end
      tx_rd_byte_q <= (state_q == StSend) ? rd_byte_d : 8'd0;
    end
  end

  always_comb begin
    hdr_sh    = hdr_q << {tx_rd_idx[5:0], 3'b000};
    pay_off   = tx_rd_idx - 16'd42;
    rd_byte_d = 8'd0;
    if (tx_rd_idx < 16'd42) begin
      rd_byte_d = hdr_sh[335:328];
    end else if (!src_arp_q && tx_rd_idx < 16'd42 + len_q) begin
      rd_byte_d = mem[{rd_bank_q, pay_off[ADDR_W-1:0]}];
    end
  end

  assign tx_req       = (state_q == StReq);
  assign tx_len       = tx_req ? frame_len : 16'd0;
  assign tx_rd_byte   = tx_rd_byte_q;
  assign rx_drop_cnt  = rx_drop_cnt_q;
  assign tx_frame_cnt = tx_frame_cnt_q;

endmodule
